display_page_sequencer: RTL and testbench
=========================================

// Module: display_page_sequencer
// PURPOSE
//  Scheduler for the 4-digit 7-segment display driver. Shares the 32-bit segment word between
//  NUM_SRC miner status sources (nonce, hashrate, ...) and one preempting alert (golden nonce).
//  Each 32-bit value shows as two 4-hex-digit pages (hi, lo). Pages rotate on a dwell timer.
//  Output word feeds the display driver directly. It is active-high; the driver inverts it.
// PARAMETERS
//  NUM_SRC       4           number of status sources (1..8)
//  DWELL_CYCLES  50_000_000  clk cycles each scan page is shown (>=2)
//  ALERT_CYCLES  100_000_000 clk cycles each alert page is shown (>=2)
//  CNT_W         27          dwell/alert counter width; must hold max(DWELL,ALERT)-1
// PORTS
//  clk           in   1            system clock
//  reset         in   1            synchronous, active-high reset
//  src_data      in   NUM_SRC*32   source i value at [32*i+31:32*i]
//  src_valid     in   NUM_SRC      source i is shown only while its bit is 1
//  freeze        in   1            1 = hold current scan page (dwell counter stalls)
//  alert_req     in   1            level request; held high until alert_ack
//  alert_data    in   32           alert value; sampled in the acknowledge cycle
//  alert_ack     out  1            one-cycle pulse; alert accepted, alert_data latched
//  alert_active  out  1            1 while an alert page is displayed
//  page_src      out  3            index of the source currently shown (scan only)
//  page_hi       out  1            1 = upper 16 bits shown, 0 = lower
//  word          out  32           segment bytes; [31:24] leftmost digit; bit0=a..bit6=g, bit7=dp
// BEHAVIOUR
//  - Reset: state SCAN, src 0, hi half, counter 0. Outputs: word=0, alert_ack=0,
//    alert_active=0, page_src=0, page_hi=1. All outputs are registered.
//  - Latency: word/page_*/alert_active show the state selected in the previous cycle.
//    Changes in src_data reach word 1 cycle later. Scan data is live, not snapshotted.
//  - Font: hex nibble to 7-seg, 0..F = 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//    Digit k (k=3 leftmost) shows nibble k of the selected half.
//    The dp of byte3 is 1 on hi pages and 0 on lo pages.
//  - SCAN: counter increments each cycle unless freeze=1.
//    When the counter reaches DWELL_CYCLES-1, it clears and the page advances.
//    hi -> lo of the same source. lo -> hi of the next valid source, round-robin,
//    wrapping NUM_SRC-1 -> 0. A lone valid source alternates hi/lo.
//  - Current source goes invalid mid-dwell: next cycle, jump to the next valid source's hi page
//    and clear the counter. This happens even when freeze=1.
//  - No valid source: word = 0x40404040 (dashes) and the counter is held at 0.
//    When any source becomes valid, show its hi page from the next cycle.
//  - Alert accept: only in SCAN with alert_req=1. In that cycle, latch alert_data, pulse
//    alert_ack, save the scan src, clear the counter, go to ALERT_HI.
//    Acceptance takes precedence over a dwell advance in the same cycle.
//  - ALERT_HI: show latched hi half for ALERT_CYCLES, then ALERT_LO for ALERT_CYCLES.
//    Then return to SCAN at the saved src's hi page, counter 0. If the saved src is now
//    invalid, apply the invalid-source rule.
//  - freeze has no effect on ALERT_* states.
//  - alert_req during ALERT_*: not acked. It is accepted on the first SCAN cycle after return.
//    The new alert shows without a scan page in between.
//  - reset has priority over everything, including mid-alert: any latched alert is discarded.
// STRUCTURE
//  - Shared package display_pkg: 16-entry SEG_FONT constant, SEG_DASH=8'h40, SEG_BLANK=8'h00,
//    SEG_DP=8'h80, state typedef {SCAN, ALERT_HI, ALERT_LO}.
//  - Sub-module hex7seg (4-bit nibble -> 8-bit pattern), instantiated 4x.
//  - Top holds the FSM, counter, round-robin next-valid finder and output registers.
// TESTING (DWELL_CYCLES=4, ALERT_CYCLES=6, NUM_SRC=4)
//  1. reset; src0=0x1234ABCD, valid=0001 -> word 0x865B4F66 for 4 cycles, then 0x777C395E,
//     then back to 0x865B4F66.
//  2. valid=1001 -> page_src/page_hi sequence 0h,0l,3h,3l,0h, each held 4 cycles.
//     Drop valid[3] mid-3h -> 0h on next cycle.
//  3. valid=0000 -> word 0x40404040 steady; set valid=0100 -> src2 hi page next cycle.
//  4. alert_req with 0xDEADBEEF -> 1-cycle alert_ack; word 0xDE79775E for 6 cycles,
//     then 0x7C797971 for 6 cycles. alert_active=1 throughout; then resume saved src, hi page.
//  5. alert_req held through an alert and freeze=1 -> no ack until return.
//     Back-to-back alert follows. freeze stalls only SCAN pages.
//  6. reset asserted mid-ALERT_LO -> next cycle: all outputs at reset values, state SCAN, src 0.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// display_pkg: seven-segment font, display constants, sequencer state type and
// the round-robin helper shared by the page sequencer files.
package display_pkg;

  localparam logic [7:0] SEG_FONT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    ALERT_HI = 2'd1,
    ALERT_LO = 2'd2
  } state_t;

  // First set bit after 'from', wrapping at n; 'from' itself is checked last.
  function automatic logic [2:0] next_valid(input logic [2:0] from,
                                            input logic [7:0] valid,
                                            input int n);
    logic [2:0] r;
    int idx;
    r = from;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = int'(from) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[2:0]]) r = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// hex7seg: one hex nibble to an active-high seven-segment pattern (dp clear).
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule
`default_nettype wire

// File: rtl/display_page_sequencer.sv
`default_nettype none
// display_page_sequencer: rotates source values as hi/lo 4-digit pages on the
// display word, with a preempting two-page alert.
module display_page_sequencer
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int ALERT_CYCLES = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC*32-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic                 freeze,
  input  logic                 alert_req,
  input  logic [31:0]          alert_data,
  output logic                 alert_ack,
  output logic                 alert_active,
  output logic [2:0]           page_src,
  output logic                 page_hi,
  output logic [31:0]          word
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       src_q, src_d;
  logic             hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      alert_q, alert_d;
  logic             ack_d;

  logic [31:0] word_q, word_d;
  logic [2:0]  page_src_q;
  logic        page_hi_q, page_hi_d;
  logic        active_q, ack_q;

  logic        any_valid, cur_valid;
  logic [2:0]  nv_src;
  logic [31:0] shown;
  logic [15:0] half;
  logic [7:0]  seg [4];

  assign any_valid = |src_valid;
  assign nv_src    = next_valid(src_q, 8'(src_valid), NUM_SRC);

  always_comb begin
    cur_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_q == 3'(i)) cur_valid = src_valid[i];
  end

  // src_q is left untouched during an alert, so it doubles as the saved scan source.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    alert_d = alert_q;
    ack_d   = 1'b0;
    case (state_q)
      SCAN: begin
        if (alert_req) begin
          ack_d   = 1'b1;
          alert_d = alert_data;
          cnt_d   = '0;
          state_d = ALERT_HI;
        end else if (!any_valid) begin
          cnt_d = '0;
          hi_d  = 1'b1;
        end else if (!cur_valid) begin
          src_d = nv_src;
          hi_d  = 1'b1;
          cnt_d = '0;
        end else if (!freeze) begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (hi_q) begin
              hi_d = 1'b0;
            end else begin
              src_d = nv_src;
              hi_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ALERT_HI: begin
        if (cnt_q == ALERT_LAST) begin
          cnt_d   = '0;
          state_d = ALERT_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ALERT_LO: begin
        if (cnt_q == ALERT_LAST) begin
          cnt_d   = '0;
          state_d = SCAN;
          hi_d    = 1'b1;
          src_d   = (cur_valid || !any_valid) ? src_q : nv_src;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    shown = alert_d;
    if (state_d == SCAN) begin
      shown = '0;
      for (int i = 0; i < NUM_SRC; i++)
        if (src_d == 3'(i)) shown = src_data[32*i +: 32];
    end
  end

  assign page_hi_d = (state_d == SCAN) ? hi_d : (state_d == ALERT_HI);
  assign half      = page_hi_d ? shown[31:16] : shown[15:0];

  for (genvar k = 0; k < 4; k++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble_i (half[4*k +: 4]),
      .seg_o    (seg[k])
    );
  end

  always_comb begin
    word_d = {seg[3] | (page_hi_d ? SEG_DP : SEG_BLANK), seg[2], seg[1], seg[0]};
    if (state_d == SCAN && !any_valid) word_d = {4{SEG_DASH}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      src_q      <= 3'd0;
      hi_q       <= 1'b1;
      cnt_q      <= '0;
      alert_q    <= '0;
      word_q     <= {4{SEG_BLANK}};
      page_src_q <= 3'd0;
      page_hi_q  <= 1'b1;
      active_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      alert_q    <= alert_d;
      word_q     <= word_d;
      page_src_q <= src_d;
      page_hi_q  <= page_hi_d;
      active_q   <= (state_d != SCAN);
      ack_q      <= ack_d;
    end
  end

  assign word         = word_q;
  assign page_src     = page_src_q;
  assign page_hi      = page_hi_q;
  assign alert_active = active_q;
  assign alert_ack    = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_display_page_sequencer.sv
`default_nettype none
// tb_display_page_sequencer: directed checks of scan rotation, invalid sources,
// dashes, alerts, freeze and reset using DWELL=4, ALERT=6, NUM_SRC=4.
module tb_display_page_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         freeze;
  logic         alert_req;
  logic [31:0]  alert_data;
  logic         alert_ack;
  logic         alert_active;
  logic [2:0]   page_src;
  logic         page_hi;
  logic [31:0]  word;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] W0H = 32'h865B4F66;  // 1234 + dp
  localparam logic [31:0] W0L = 32'h777C395E;  // ABCD
  localparam logic [31:0] W3H = 32'hFF6F777C;  // 89AB + dp
  localparam logic [31:0] W2H = 32'hBF713F71;  // 0F0F + dp

  display_page_sequencer #(
    .NUM_SRC      (4),
    .DWELL_CYCLES (4),
    .ALERT_CYCLES (6),
    .CNT_W        (27)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .freeze       (freeze),
    .alert_req    (alert_req),
    .alert_data   (alert_data),
    .alert_ack    (alert_ack),
    .alert_active (alert_active),
    .page_src     (page_src),
    .page_hi      (page_hi),
    .word         (word)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_page(input string tag, input logic [2:0] s, input logic h);
    chk({tag, "_src"}, {29'd0, page_src}, {29'd0, s});
    chk({tag, "_hi"}, {31'd0, page_hi}, {31'd0, h});
  endtask

  initial begin
    reset      = 1'b1;
    src_data   = {32'h89ABCDEF, 32'h0F0F5A5A, 32'h11112222, 32'h1234ABCD};
    src_valid  = 4'b0001;
    freeze     = 1'b0;
    alert_req  = 1'b0;
    alert_data = 32'hDEADBEEF;
    tick();
    tick();
    chk("rst_word", word, 32'h0);
    chk("rst_ack", {31'd0, alert_ack}, 32'd0);
    chk("rst_active", {31'd0, alert_active}, 32'd0);
    chk_page("rst", 3'd0, 1'b1);

    // single valid source alternates hi/lo
    reset = 1'b0;
    repeat (3) begin tick(); chk("t1_hi_first", word, W0H); end
    repeat (4) begin tick(); chk("t1_lo", word, W0L); end
    tick(); chk("t1_hi_again", word, W0H);

    // two valid sources: 0h,0l,3h,3l,0h
    src_valid = 4'b1001;
    repeat (3) begin tick(); chk_page("t2_0h", 3'd0, 1'b1); end
    repeat (4) begin tick(); chk_page("t2_0l", 3'd0, 1'b0); end
    repeat (4) begin tick(); chk_page("t2_3h", 3'd3, 1'b1); chk("t2_3h_word", word, W3H); end
    repeat (4) begin tick(); chk_page("t2_3l", 3'd3, 1'b0); end
    tick(); chk_page("t2_0h_wrap", 3'd0, 1'b1);
    repeat (7) tick();
    tick(); chk_page("t2_3h_pre_drop", 3'd3, 1'b1);
    tick(); chk_page("t2_3h_mid", 3'd3, 1'b1);
    src_valid = 4'b0001;
    tick(); chk_page("t2_drop", 3'd0, 1'b1); chk("t2_drop_word", word, W0H);

    // no valid source -> dashes; then src2 appears
    src_valid = 4'b0000;
    repeat (3) begin tick(); chk("t3_dash", word, 32'h40404040); end
    src_valid = 4'b0100;
    tick(); chk_page("t3_src2", 3'd2, 1'b1); chk("t3_src2_word", word, W2H);

    // alert accept and two alert pages
    alert_req  = 1'b1;
    alert_data = 32'hDEADBEEF;
    tick();
    chk("t4_ack", {31'd0, alert_ack}, 32'd1);
    chk("t4_hi_word0", word, 32'hDE79775E);
    alert_req = 1'b0;
    tick(); chk("t4_ack_pulse", {31'd0, alert_ack}, 32'd0);
    repeat (4) begin tick(); chk("t4_hi_word", word, 32'hDE79775E); end
    repeat (6) begin
      tick();
      chk("t4_lo_word", word, 32'h7C797971);
      chk("t4_active", {31'd0, alert_active}, 32'd1);
    end
    tick();
    chk("t4_resume_active", {31'd0, alert_active}, 32'd0);
    chk_page("t4_resume", 3'd2, 1'b1);
    chk("t4_resume_word", word, W2H);

    // freeze holds scan page; alert held through an alert -> back-to-back
    freeze = 1'b1;
    repeat (6) begin tick(); chk_page("t5_frozen", 3'd2, 1'b1); end
    alert_req  = 1'b1;
    alert_data = 32'hCAFEF00D;
    tick();
    chk("t5_ack1", {31'd0, alert_ack}, 32'd1);
    chk("t5_hi1", word, 32'hB9777179);
    alert_data = 32'h13579BDF;
    repeat (5) begin tick(); chk("t5_no_ack_hi", {31'd0, alert_ack}, 32'd0); end
    chk("t5_hi1_last", word, 32'hB9777179);
    repeat (6) begin
      tick();
      chk("t5_no_ack_lo", {31'd0, alert_ack}, 32'd0);
      chk("t5_lo1", word, 32'h713F3F5E);
    end
    tick();
    chk("t5_return_no_ack", {31'd0, alert_ack}, 32'd0);
    tick();
    chk("t5_ack2", {31'd0, alert_ack}, 32'd1);
    chk("t5_hi2", word, 32'h864F6D07);
    chk("t5_active2", {31'd0, alert_active}, 32'd1);
    alert_req = 1'b0;
    repeat (5) tick();
    chk("t5_hi2_last", word, 32'h864F6D07);
    tick();
    chk("t5_lo2", word, 32'h6F7C5E71);
    chk("t5_lo2_hi", {31'd0, page_hi}, 32'd0);

    // reset mid ALERT_LO
    reset = 1'b1;
    tick();
    chk("t6_word", word, 32'h0);
    chk("t6_active", {31'd0, alert_active}, 32'd0);
    chk("t6_ack", {31'd0, alert_ack}, 32'd0);
    chk_page("t6", 3'd0, 1'b1);
    reset     = 1'b0;
    freeze    = 1'b0;
    src_valid = 4'b0001;
    tick();
    chk("t6_scan_word", word, W0H);
    chk("t6_scan_active", {31'd0, alert_active}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
